// File: rtl/task_cmd_issuer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// task_cmd_issuer
//
// Purpose:
//   Accepts task-management commands (create / resume / suspend / delay) into
//   a small in-order FIFO and issues them one at a time to the task lists
//   manager. Each command becomes a single-cycle strobe with its operands.
//   After each strobe the issuer stays idle for GAP_CYCLES cycles. Illegal
//   opcodes are dropped without a strobe and raise a sticky error flag.
//
// Configuration:
//   TASK_CMD_DLY_EN - when defined, opcode 3 (delay) is legal and drives
//                     ins_dlylist_out / valdelay_out. When undefined, opcode 3
//                     is illegal, both outputs are tied 0, and the delay field
//                     is not stored.
//
// Parameters:
//   FIFO_DEPTH  command FIFO entries (power of two, 2..16)
//   GAP_CYCLES  idle cycles after each strobe (0..15)
//
// Ports:
//   aclk, areset         clock (rising edge), async active-high reset
//   cmd_valid_in         command offered
//   cmd_ready_out        FIFO not full (0 while in reset)
//   cmd_op_in            0 create, 1 resume, 2 suspend, 3 delay, 4-7 illegal
//   cmd_id_in            task id
//   cmd_tcb_in           TCB address (create only)
//   cmd_pri_in           priority (create only)
//   cmd_delay_in         delay value (delay only)
//   insnew_rdylist_out   create strobe
//   ins_rdylist_out      resume strobe
//   susp_rdylist_out     suspend strobe
//   ins_dlylist_out      delay-list insert strobe
//   idtask_out           task id of the issued command
//   addrtcb_out          TCB address of the issued command (0 unless create)
//   priority_out         priority of the issued command (0 unless create)
//   valdelay_out         delay of the issued command (0 unless delay)
//   busy_out             FIFO non-empty or issuer not idle
//   err_badop_out        sticky illegal-opcode flag
//   fifo_count_out       FIFO occupancy
// -----------------------------------------------------------------------------
module task_cmd_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [2:0]  cmd_op_in,
  input  logic [7:0]  cmd_id_in,
  input  logic [31:0] cmd_tcb_in,
  input  logic [5:0]  cmd_pri_in,
  input  logic [31:0] cmd_delay_in,
  output logic        insnew_rdylist_out,
  output logic        ins_rdylist_out,
  output logic        susp_rdylist_out,
  output logic        ins_dlylist_out,
  output logic [7:0]  idtask_out,
  output logic [31:0] addrtcb_out,
  output logic [5:0]  priority_out,
  output logic [31:0] valdelay_out,
  output logic        busy_out,
  output logic        err_badop_out,
  output logic [4:0]  fifo_count_out
);

  localparam int         PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_C  = 5'(FIFO_DEPTH);
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  localparam logic [2:0] OP_CREATE  = 3'd0;
  localparam logic [2:0] OP_RESUME  = 3'd1;
  localparam logic [2:0] OP_SUSPEND = 3'd2;
  localparam logic [2:0] OP_DELAY   = 3'd3;

  // Entry layout, MSB first: op(3) id(8) tcb(32) pri(6) [delay(32)]
`ifdef TASK_CMD_DLY_EN
  localparam int ENT_W = 81;
`else
  localparam int ENT_W = 49;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_t;

  // FIFO storage and control
  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [4:0]       r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_slot;
  logic             w_legal;
  logic [ENT_W-1:0] w_wr_entry;
  logic [ENT_W-1:0] w_head;
  logic [2:0]       w_head_op;
  logic [7:0]       w_head_id;
  logic [31:0]      w_head_tcb;
  logic [5:0]       w_head_pri;

  // Issuer state and registered outputs
  state_t      r_state;
  logic [3:0]  r_gap_cnt;
  logic        r_insnew;
  logic        r_ins;
  logic        r_susp;
  logic [7:0]  r_idtask;
  logic [31:0] r_addrtcb;
  logic [5:0]  r_priority;
  logic        r_err;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == 5'd0);

  // Readiness depends only on registered occupancy, so a pop in the same
  // cycle never frees a slot for a push to a full FIFO.
  assign cmd_ready_out = ~w_full & ~areset;
  assign w_push        = cmd_valid_in & cmd_ready_out;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_op  = w_head[ENT_W-1  -: 3];
  assign w_head_id  = w_head[ENT_W-4  -: 8];
  assign w_head_tcb = w_head[ENT_W-12 -: 32];
  assign w_head_pri = w_head[ENT_W-44 -: 6];

`ifdef TASK_CMD_DLY_EN
  logic [31:0] w_head_dly;
  logic        r_insdly;
  logic [31:0] r_valdelay;

  assign w_wr_entry = {cmd_op_in, cmd_id_in, cmd_tcb_in, cmd_pri_in, cmd_delay_in};
  assign w_head_dly = w_head[31:0];
  assign w_legal    = (w_head_op <= OP_DELAY);
  assign ins_dlylist_out = r_insdly;
  assign valdelay_out    = r_valdelay;
`else
  logic w_unused_delay;

  assign w_wr_entry      = {cmd_op_in, cmd_id_in, cmd_tcb_in, cmd_pri_in};
  assign w_unused_delay  = ^cmd_delay_in;
  assign w_legal         = (w_head_op <= OP_SUSPEND);
  assign ins_dlylist_out = 1'b0;
  assign valdelay_out    = 32'd0;
`endif

  // A pop slot opens in IDLE, at the end of ISSUE when there is no gap, and
  // in the last GAP cycle; the latter two give one command per 1+GAP_CYCLES.
  assign w_slot = (r_state == S_IDLE) ||
                  ((r_state == S_ISSUE) && (GAP_CYCLES == 0)) ||
                  ((r_state == S_GAP) && (r_gap_cnt == GAP_LAST));
  assign w_pop  = w_slot & ~w_empty;

  assign insnew_rdylist_out = r_insnew;
  assign ins_rdylist_out    = r_ins;
  assign susp_rdylist_out   = r_susp;
  assign idtask_out         = r_idtask;
  assign addrtcb_out        = r_addrtcb;
  assign priority_out       = r_priority;
  assign err_badop_out      = r_err;
  assign fifo_count_out     = r_count;
  assign busy_out           = ~w_empty | (r_state != S_IDLE);

  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 5'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state    <= S_IDLE;
      r_gap_cnt  <= 4'd0;
      r_insnew   <= 1'b0;
      r_ins      <= 1'b0;
      r_susp     <= 1'b0;
      r_idtask   <= 8'd0;
      r_addrtcb  <= 32'd0;
      r_priority <= 6'd0;
      r_err      <= 1'b0;
`ifdef TASK_CMD_DLY_EN
      r_insdly   <= 1'b0;
      r_valdelay <= 32'd0;
`endif
    end else begin
      r_insnew <= 1'b0;
      r_ins    <= 1'b0;
      r_susp   <= 1'b0;
`ifdef TASK_CMD_DLY_EN
      r_insdly <= 1'b0;
`endif
      if (w_pop) begin
        if (w_legal) begin
          r_state    <= S_ISSUE;
          r_insnew   <= (w_head_op == OP_CREATE);
          r_ins      <= (w_head_op == OP_RESUME);
          r_susp     <= (w_head_op == OP_SUSPEND);
          r_idtask   <= w_head_id;
          r_addrtcb  <= (w_head_op == OP_CREATE) ? w_head_tcb : 32'd0;
          r_priority <= (w_head_op == OP_CREATE) ? w_head_pri : 6'd0;
`ifdef TASK_CMD_DLY_EN
          r_insdly   <= (w_head_op == OP_DELAY);
          r_valdelay <= (w_head_op == OP_DELAY) ? w_head_dly : 32'd0;
`endif
        end else begin
          // Illegal command is discarded; operands keep the last issued values.
          r_state <= S_IDLE;
          r_err   <= 1'b1;
        end
      end else begin
        case (r_state)
          S_ISSUE: begin
            if (GAP_CYCLES > 0) begin
              r_state   <= S_GAP;
              r_gap_cnt <= 4'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
              r_state <= S_IDLE;
            end else begin
              r_gap_cnt <= r_gap_cnt + 4'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_task_cmd_issuer.sv
`timescale 1ns/1ps
module tb_task_cmd_issuer;

  localparam int GAP = 1;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid_in = 1'b0;
  logic        cmd_ready_out;
  logic [2:0]  cmd_op_in = 3'd0;
  logic [7:0]  cmd_id_in = 8'd0;
  logic [31:0] cmd_tcb_in = 32'd0;
  logic [5:0]  cmd_pri_in = 6'd0;
  logic [31:0] cmd_delay_in = 32'd0;
  logic        insnew_rdylist_out;
  logic        ins_rdylist_out;
  logic        susp_rdylist_out;
  logic        ins_dlylist_out;
  logic [7:0]  idtask_out;
  logic [31:0] addrtcb_out;
  logic [5:0]  priority_out;
  logic [31:0] valdelay_out;
  logic        busy_out;
  logic        err_badop_out;
  logic [4:0]  fifo_count_out;

  task_cmd_issuer #(.FIFO_DEPTH(4), .GAP_CYCLES(GAP)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_op_in(cmd_op_in), .cmd_id_in(cmd_id_in), .cmd_tcb_in(cmd_tcb_in),
    .cmd_pri_in(cmd_pri_in), .cmd_delay_in(cmd_delay_in),
    .insnew_rdylist_out(insnew_rdylist_out), .ins_rdylist_out(ins_rdylist_out),
    .susp_rdylist_out(susp_rdylist_out), .ins_dlylist_out(ins_dlylist_out),
    .idtask_out(idtask_out), .addrtcb_out(addrtcb_out),
    .priority_out(priority_out), .valdelay_out(valdelay_out),
    .busy_out(busy_out), .err_badop_out(err_badop_out),
    .fifo_count_out(fifo_count_out)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  id;
    logic [31:0] tcb;
    logic [5:0]  pri;
    logic [31:0] dly;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   n_strobes = 0;
  bit   bad_seen  = 1'b0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic bit is_legal(input logic [2:0] op);
`ifdef TASK_CMD_DLY_EN
    return op <= 3'd3;
`else
    return op <= 3'd2;
`endif
  endfunction

  // Reference model: every accepted legal command is expected to appear, in
  // order, as one strobe carrying only the operands its opcode uses.
  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      exp_q.delete();
      bad_seen = 1'b0;
    end else if (cmd_valid_in && cmd_ready_out) begin
      if (is_legal(cmd_op_in)) begin
        exp_t e;
        e.op  = cmd_op_in;
        e.id  = cmd_id_in;
        e.tcb = (cmd_op_in == 3'd0) ? cmd_tcb_in : 32'd0;
        e.pri = (cmd_op_in == 3'd0) ? cmd_pri_in : 6'd0;
        e.dly = (cmd_op_in == 3'd3) ? cmd_delay_in : 32'd0;
        exp_q.push_back(e);
      end else begin
        bad_seen = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a strobe is seen.
  int cyc = 0;
  int last_strb = -1000;
  always @(negedge aclk) begin
    int   ns;
    int   act_op;
    exp_t e;
    if (areset) begin
      last_strb = -1000;
    end else begin
      cyc++;
      ns = int'(insnew_rdylist_out) + int'(ins_rdylist_out) +
           int'(susp_rdylist_out) + int'(ins_dlylist_out);
      if (ns > 1) chk("strobe_onehot", ns, 1);
      if (ns == 1) begin
        n_strobes++;
        chk("strobe_spacing_ok", longint'(cyc - last_strb >= 1 + GAP), 1);
        last_strb = cyc;
        act_op = insnew_rdylist_out ? 0 : ins_rdylist_out ? 1 :
                 susp_rdylist_out ? 2 : 3;
        if (exp_q.size() == 0) begin
          chk("sb_strobe_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_op", act_op, e.op);
          chk("sb_id", idtask_out, e.id);
          chk("sb_tcb", addrtcb_out, e.tcb);
          chk("sb_pri", priority_out, e.pri);
          chk("sb_dly", valdelay_out, e.dly);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [2:0] op, input logic [7:0] id,
                       input logic [31:0] tcb, input logic [5:0] pri,
                       input logic [31:0] dly);
    cmd_valid_in = 1'b1;
    cmd_op_in    = op;
    cmd_id_in    = id;
    cmd_tcb_in   = tcb;
    cmd_pri_in   = pri;
    cmd_delay_in = dly;
  endtask

  task automatic drain();
    bit done = 1'b0;
    cmd_valid_in = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge aclk);
      if (exp_q.size() == 0 && !busy_out) done = 1'b1;
    end
    chk("drain_complete", done, 1);
  endtask

  initial begin
    int  p1, p2, id1, id2, s0;
    bit  acc;
    logic [2:0] rop;

    // Reset state
    repeat (3) @(negedge aclk);
    #1;
    chk("rst_ready", cmd_ready_out, 0);
    chk("rst_count", fifo_count_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_err", err_badop_out, 0);
    chk("rst_insnew", insnew_rdylist_out, 0);
    chk("rst_idtask", idtask_out, 0);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("rel_ready", cmd_ready_out, 1);

    // Single create, latency and operand hold
    @(negedge aclk);
    drive(3'd0, 8'd0, 32'h0123_4567, 6'd2, 32'd0);
    @(negedge aclk);
    cmd_valid_in = 1'b0;
    chk("lat_c1_insnew", insnew_rdylist_out, 0);
    chk("lat_c1_busy", busy_out, 1);
    @(negedge aclk);
    chk("lat_c2_insnew", insnew_rdylist_out, 1);
    chk("lat_c2_id", idtask_out, 0);
    chk("lat_c2_tcb", addrtcb_out, 32'h0123_4567);
    chk("lat_c2_pri", priority_out, 2);
    @(negedge aclk);
    chk("lat_c3_insnew", insnew_rdylist_out, 0);
    chk("hold_tcb", addrtcb_out, 32'h0123_4567);
    chk("hold_pri", priority_out, 2);
    drain();

    // Back-to-back creates: strobes 1+GAP cycles apart, in order
    @(negedge aclk);
    drive(3'd0, 8'd1, $urandom, 6'h2A, 32'd0);
    @(negedge aclk);
    drive(3'd0, 8'd2, $urandom, 6'h05, 32'd0);
    p1 = -1; p2 = -1; id1 = -1; id2 = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge aclk);
      if (i == 1) cmd_valid_in = 1'b0;
      if (insnew_rdylist_out) begin
        if (p1 < 0) begin p1 = i; id1 = idtask_out; end
        else if (p2 < 0) begin p2 = i; id2 = idtask_out; end
      end
    end
    chk("b2b_first_pos", p1, 1);
    chk("b2b_second_pos", p2, 3);
    chk("b2b_first_id", id1, 1);
    chk("b2b_second_id", id2, 2);
    drain();

    // Fill: continuous offers; FIFO full after 7 accepts, 8th refused while a pop happens
    s0 = n_strobes;
    @(negedge aclk);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        chk("full_count", fifo_count_out, 4);
        chk("full_ready", cmd_ready_out, 0);
      end
      drive(3'd0, 8'(8'h40 + i), $urandom, 6'($urandom), 32'd0);
      @(posedge aclk);
      acc = cmd_ready_out;
      chk($sformatf("fill_accept_%0d", i), acc, (i < 7) ? 1 : 0);
      @(negedge aclk);
    end
    cmd_valid_in = 1'b0;
    chk("full_pop_no_push_count", fifo_count_out, 3);
    drain();
    chk("fill_strobes", n_strobes - s0, 7);
    chk("fill_err_clear", err_badop_out, 0);

    // Reset during ISSUE with three queued
    @(negedge aclk);
    for (int i = 0; i < 6; i++) begin
      drive(3'd0, 8'(8'h60 + i), $urandom, 6'($urandom), 32'd0);
      @(negedge aclk);
    end
    cmd_valid_in = 1'b0;
    chk("pre_rst_insnew", insnew_rdylist_out, 1);
    chk("pre_rst_count", fifo_count_out, 3);
    #1 areset = 1'b1;
    #1;
    chk("arst_insnew", insnew_rdylist_out, 0);
    chk("arst_count", fifo_count_out, 0);
    chk("arst_busy", busy_out, 0);
    chk("arst_ready", cmd_ready_out, 0);
    chk("arst_idtask", idtask_out, 0);
    chk("arst_tcb", addrtcb_out, 0);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("arel_ready", cmd_ready_out, 1);
    s0 = n_strobes;
    repeat (10) @(negedge aclk);
    chk("arel_no_strobe", n_strobes - s0, 0);
    chk("arel_err", err_badop_out, 0);

    // Opcode 3
    @(negedge aclk);
    drive(3'd3, 8'd1, $urandom, 6'($urandom), 32'h10);
    @(negedge aclk);
    cmd_valid_in = 1'b0;
    chk("dly_c1_strobe", ins_dlylist_out, 0);
    @(negedge aclk);
`ifdef TASK_CMD_DLY_EN
    chk("dly_strobe", ins_dlylist_out, 1);
    chk("dly_val", valdelay_out, 32'h10);
    chk("dly_id", idtask_out, 1);
    chk("dly_err", err_badop_out, 0);
`else
    chk("dly_no_strobe", ins_dlylist_out, 0);
    chk("dly_no_other", insnew_rdylist_out | ins_rdylist_out | susp_rdylist_out, 0);
    chk("dly_val_tied", valdelay_out, 0);
    chk("dly_err", err_badop_out, 1);
`endif
    drain();

    // Illegal opcode followed by suspend with no gap
    @(negedge aclk);
    drive(3'd6, 8'd9, $urandom, 6'($urandom), $urandom);
    @(negedge aclk);
    drive(3'd2, 8'd3, $urandom, 6'($urandom), $urandom);
    @(negedge aclk);
    cmd_valid_in = 1'b0;
    chk("bad_err_set", err_badop_out, 1);
    chk("bad_no_strobe", susp_rdylist_out, 0);
    @(negedge aclk);
    chk("susp_strobe", susp_rdylist_out, 1);
    chk("susp_id", idtask_out, 3);
    chk("susp_tcb_zero", addrtcb_out, 0);
    chk("susp_pri_zero", priority_out, 0);
    chk("bad_err_sticky", err_badop_out, 1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      @(negedge aclk);
      if ($urandom_range(0, 2) != 0) begin
        rop = ($urandom_range(0, 15) < 14) ? 3'($urandom_range(0, 3))
                                           : 3'($urandom_range(4, 7));
        drive(rop, 8'($urandom), $urandom, 6'($urandom), $urandom);
      end else begin
        cmd_valid_in = 1'b0;
      end
    end
    drain();
    chk("rand_err", err_badop_out, bad_seen);
    chk("rand_count_empty", fifo_count_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
